// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side drain controller.
// Used by fifo_rd_drain and fifo_rd_skid; FIFO_RD_CNT_EN lives in the top.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } rd_state_t;

    typedef logic [1:0] occ_t;

    localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer: head_data is the oldest word, occ counts held words (0..2).
// clear drops both entries and takes priority over push/pop.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output occ_t             occ,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] tail_data;
    occ_t             occ_rem;

    // entries left once this cycle's pop has been taken; the pushed word lands behind them
    assign occ_rem = occ - occ_t'(pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ       <= '0;
            head_data <= '0;
            tail_data <= '0;
        end else if (clear) begin
            occ <= '0;
        end else begin
            occ <= occ_rem + occ_t'(push);
            if (pop) begin
                head_data <= tail_data;
            end
            if (push) begin
                if (occ_rem == '0) begin
                    head_data <= push_data;
                end else begin
                    tail_data <= push_data;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side FIFO drain: FSM, pull logic and flush counter in front of a skid buffer.
// Define FIFO_RD_CNT_EN to add the xfer_cnt delivered-word counter port.
module fifo_rd_drain
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [WIDTH-1:0]      fifo_data,
    output logic                  fifo_pull,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  flush_done,
    output logic                  busy
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [XFER_CNT_W-1:0] xfer_cnt
`endif
);

    // state | meaning
    // IDLE  | no pulls; skid contents still presented
    // RUN   | pull into skid while it has room
    // FLUSH | pull and discard until empty or DEPTH pulls made
    localparam int FC_W = $clog2(DEPTH + 1);

    rd_state_t       state;
    rd_state_t       state_nxt;
    logic [FC_W-1:0] flush_cnt;
    logic            flush_hit;
    logic            clear;
    logic            done_nxt;
    logic            push;
    logic            accept;
    occ_t            occ;

    assign flush_hit = (flush_cnt >= FC_W'(DEPTH));
    assign push      = fifo_pull && (state == RUN);
    assign out_valid = (occ != '0);
    assign accept    = out_valid && out_ready;
    assign busy      = (state == FLUSH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            flush_cnt  <= '0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_done <= done_nxt;
            if (clear) begin
                flush_cnt <= '0;
            end else if (busy && fifo_pull) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        fifo_pull = 1'b0;
        clear     = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    state_nxt = FLUSH;
                    clear     = 1'b1;
                end else if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                fifo_pull = !fifo_empty && (occ < 2'd2);
                if (flush) begin
                    state_nxt = FLUSH;
                    clear     = 1'b1;
                end else if (!en) begin
                    state_nxt = IDLE;
                end
            end
            FLUSH: begin
                fifo_pull = !fifo_empty && !flush_hit;
                if (fifo_empty || flush_hit) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef FIFO_RD_CNT_EN
    // counts deliveries only; flush leaves it alone, wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xfer_cnt <= '0;
        end else if (accept) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end
    end
`endif

    fifo_rd_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_data),
        .pop       (accept),
        .clear     (clear),
        .occ       (occ),
        .head_data (out_data)
    );

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain with a behavioural 15-deep FIFO in front of it.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_fifo_rd_drain;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        fifo_pull;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        flush_done;
    logic        busy;
`ifdef FIFO_RD_CNT_EN
    logic [15:0] xfer_cnt;
`endif

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] words [0:31];

    // behavioural FIFO
    logic [31:0] mem [0:63];
    logic [31:0] wr_ptr = '0;
    logic [31:0] rd_ptr = '0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en && ((wr_ptr - rd_ptr) < 32'd15)) begin
            mem[wr_ptr[5:0]] <= wr_data;
            wr_ptr <= wr_ptr + 32'd1;
        end
        if (fifo_pull && !fifo_empty) begin
            rd_ptr <= rd_ptr + 32'd1;
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_data  = mem[rd_ptr[5:0]];

    fifo_rd_drain #(
        .WIDTH (32),
        .DEPTH (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pull  (fifo_pull),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush_done (flush_done),
        .busy       (busy)
`ifdef FIFO_RD_CNT_EN
        ,
        .xfer_cnt   (xfer_cnt)
`endif
    );

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en = 1'b1;
            wr_data = words[i];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic clear_fifo();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            #1;
            if (flush_done) seen = 1'b1;
            @(negedge clk);
        end
        n_total++;
        if (!seen || !fifo_empty) $display("FAIL clear_fifo: done=%0b empty=%0b, want 1 1", seen, fifo_empty);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
        n_total++;
        if (fifo_pull !== 1'b0) $display("FAIL reset_pull: got %b want 0", fifo_pull); else n_pass++;
        n_total++;
        if (busy !== 1'b0 || flush_done !== 1'b0) $display("FAIL reset_busy_done: got %b %b want 0 0", busy, flush_done); else n_pass++;
        n_total++;
        if (out_data !== 32'h0) $display("FAIL reset_data: got %h want 0", out_data); else n_pass++;
`ifdef FIFO_RD_CNT_EN
        n_total++;
        if (xfer_cnt !== 16'h0) $display("FAIL reset_xfer_cnt: got %0d want 0", xfer_cnt); else n_pass++;
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_stream();
        int first_pull, last_pull, n_pull, first_val, last_val, n_acc;
        first_pull = -1; last_pull = -1; n_pull = 0;
        first_val = -1; last_val = -1; n_acc = 0;
        for (int i = 0; i < 15; i++) words[i] = $urandom;
        preload(15);
        en = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (fifo_pull) begin
                if (first_pull < 0) first_pull = c;
                last_pull = c;
                n_pull++;
            end
            if (out_valid && out_ready) begin
                if (first_val < 0) first_val = c;
                last_val = c;
                n_total++;
                if (n_acc >= 15) $display("FAIL stream_extra_word: got %h want none", out_data);
                else if (out_data !== words[n_acc]) $display("FAIL stream_word%0d: got %h want %h", n_acc, out_data, words[n_acc]);
                else n_pass++;
                n_acc++;
            end
            @(negedge clk);
        end
        en = 1'b0;
        n_total++;
        if (n_pull != 15) $display("FAIL stream_pull_count: got %0d want 15", n_pull); else n_pass++;
        n_total++;
        if (last_pull - first_pull != 14) $display("FAIL stream_pull_span: got %0d want 14", last_pull - first_pull); else n_pass++;
        n_total++;
        if (first_val != first_pull + 1) $display("FAIL stream_latency: got %0d want %0d", first_val, first_pull + 1); else n_pass++;
        n_total++;
        if (n_acc != 15 || last_val - first_val != 14) $display("FAIL stream_back_to_back: got %0d words over %0d cycles want 15 over 14", n_acc, last_val - first_val); else n_pass++;
    endtask

    task automatic test_backpressure();
        int n_pull, n_acc;
        bit stable_ok;
        logic [31:0] got [0:7];
        n_pull = 0; n_acc = 0; stable_ok = 1'b1;
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        preload(3);
        en = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (fifo_pull) n_pull++;
            if (out_valid && out_data !== 32'h11) stable_ok = 1'b0;
            @(negedge clk);
        end
        #1;
        n_total++;
        if (n_pull != 2) $display("FAIL bp_pull_count: got %0d want 2", n_pull); else n_pass++;
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 32'h11) $display("FAIL bp_head: got v=%b d=%h want 1 00000011", out_valid, out_data); else n_pass++;
        n_total++;
        if (!stable_ok) $display("FAIL bp_stable: got unstable head want 00000011 held"); else n_pass++;
        @(negedge clk);
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid && out_ready) begin
                if (n_acc < 8) got[n_acc] = out_data;
                n_acc++;
            end
            @(negedge clk);
        end
        en = 1'b0;
        n_total++;
        if (n_acc != 3) $display("FAIL bp_word_count: got %0d want 3", n_acc); else n_pass++;
        for (int i = 0; i < 3 && i < n_acc; i++) begin
            n_total++;
            if (got[i] !== words[i]) $display("FAIL bp_word%0d: got %h want %h", i, got[i], words[i]); else n_pass++;
        end
    endtask

    task automatic test_flush();
        int n_busy, n_fp, n_done, first_done, last_busy;
        bit saw_valid, busy0;
        n_busy = 0; n_fp = 0; n_done = 0; first_done = -1; last_busy = -1;
        saw_valid = 1'b0; busy0 = 1'b0;
        for (int i = 0; i < 10; i++) words[i] = 32'h100 + i;
        preload(10);
        en = 1'b1;
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        flush = 1'b1;
        en = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (c == 0) busy0 = busy;
            if (busy) begin
                n_busy++;
                last_busy = c;
                if (fifo_pull) n_fp++;
            end
            if (out_valid) saw_valid = 1'b1;
            if (flush_done) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
            @(negedge clk);
        end
        n_total++;
        if (busy0 !== 1'b1) $display("FAIL flush_busy_entry: got %b want 1", busy0); else n_pass++;
        n_total++;
        if (n_fp != 8) $display("FAIL flush_pull_count: got %0d want 8", n_fp); else n_pass++;
        n_total++;
        if (n_busy != 9) $display("FAIL flush_busy_cycles: got %0d want 9", n_busy); else n_pass++;
        n_total++;
        if (n_done != 1 || first_done != last_busy + 1) $display("FAIL flush_done_pulse: got %0d pulses at %0d want 1 at %0d", n_done, first_done, last_busy + 1); else n_pass++;
        n_total++;
        if (saw_valid) $display("FAIL flush_valid_drop: got out_valid 1 want 0"); else n_pass++;
        n_total++;
        if (!fifo_empty || busy !== 1'b0) $display("FAIL flush_end: got empty=%b busy=%b want 1 0", fifo_empty, busy); else n_pass++;
        out_ready = 1'b1;
    endtask

    task automatic test_flush_writer();
        int n_busy, n_fp, n_done, first_done, last_busy;
        n_busy = 0; n_fp = 0; n_done = 0; first_done = -1; last_busy = -1;
        for (int i = 0; i < 3; i++) words[i] = 32'h200 + i;
        preload(3);
        wr_en = 1'b1;
        wr_data = 32'h300;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (busy) begin
                n_busy++;
                last_busy = c;
                if (fifo_pull) n_fp++;
            end
            if (flush_done) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        n_total++;
        if (n_fp != 15) $display("FAIL fw_pull_count: got %0d want 15", n_fp); else n_pass++;
        n_total++;
        if (n_busy != 16) $display("FAIL fw_busy_cycles: got %0d want 16", n_busy); else n_pass++;
        n_total++;
        if (n_done != 1 || first_done != last_busy + 1) $display("FAIL fw_done_pulse: got %0d pulses at %0d want 1 at %0d", n_done, first_done, last_busy + 1); else n_pass++;
        clear_fifo();
    endtask

    task automatic test_reset_mid();
        int n_pull, n_acc;
        bit saw_valid;
        logic [31:0] got [0:3];
        n_pull = 0; n_acc = 0; saw_valid = 1'b0;
        for (int i = 0; i < 4; i++) words[i] = 32'h400 + i;
        preload(4);
        en = 1'b1;
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL rm_pre_valid: got %b want 1", out_valid); else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || fifo_pull !== 1'b0) $display("FAIL rm_async: got v=%b p=%b want 0 0", out_valid, fifo_pull); else n_pass++;
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (fifo_pull) n_pull++;
            if (out_valid) saw_valid = 1'b1;
            @(negedge clk);
        end
        n_total++;
        if (n_pull != 0 || saw_valid) $display("FAIL rm_hold_off: got pulls=%0d valid=%b want 0 0", n_pull, saw_valid); else n_pass++;
        en = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid && out_ready) begin
                if (n_acc < 4) got[n_acc] = out_data;
                n_acc++;
            end
            @(negedge clk);
        end
        en = 1'b0;
        n_total++;
        if (n_acc != 2) $display("FAIL rm_resume_count: got %0d want 2", n_acc); else n_pass++;
        for (int i = 0; i < 2 && i < n_acc; i++) begin
            n_total++;
            if (got[i] !== words[i + 2]) $display("FAIL rm_resume_word%0d: got %h want %h", i, got[i], words[i + 2]); else n_pass++;
        end
    endtask

`ifdef FIFO_RD_CNT_EN
    task automatic test_xfer_cnt();
        int pushed, n_acc;
        pushed = 0; n_acc = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        en = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (pushed < 20) begin
                wr_en = 1'b1;
                wr_data = 32'h500 + pushed;
                pushed++;
            end else begin
                wr_en = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                n_total++;
                if (out_data !== 32'h500 + n_acc) $display("FAIL cnt_word%0d: got %h want %h", n_acc, out_data, 32'h500 + n_acc); else n_pass++;
                n_acc++;
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        en = 1'b0;
        #1;
        n_total++;
        if (n_acc != 20 || xfer_cnt !== 16'd20) $display("FAIL cnt_value: got words=%0d cnt=%0d want 20 20", n_acc, xfer_cnt); else n_pass++;
        clear_fifo();
        #1;
        n_total++;
        if (xfer_cnt !== 16'd20) $display("FAIL cnt_after_flush: got %0d want 20", xfer_cnt); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_flush_writer();
        test_reset_mid();
`ifdef FIFO_RD_CNT_EN
        test_xfer_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
